// File: rtl/core_pkg.sv
// Shared core-wide constants: datapath width, reset vector, NOP encoding, PC step.
package core_pkg;

    localparam int unsigned      XLEN      = 32;
    localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_slot_fifo.sv
// In-order slot queue for the fetch stage. A slot is reserved when a request
// is accepted, filled when its response returns (oldest unfilled slot first)
// and popped from the head once filled. flush_i empties everything.
module fetch_slot_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            head_filled_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [CW-1:0]   used_o,
    output logic [CW-1:0]   pend_o
);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  pc_d    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  instr_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fptr_q, fptr_d;
    logic [CW-1:0]    used_q, used_d;
    logic [CW-1:0]    pend_q, pend_d;
    logic             fill_ok;

    // A response with no reserved-but-unfilled slot is ignored.
    assign fill_ok       = fill_i && (pend_q != '0);
    assign head_filled_o = filled_q[head_q];
    assign head_pc_o     = pc_q[head_q];
    assign head_instr_o  = instr_q[head_q];
    assign used_o        = used_q;
    assign pend_o        = pend_q;

    // Next-state: reserve at tail, fill at fill pointer, release at head.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        used_d   = used_q;
        pend_d   = pend_q;
        if (flush_i) begin
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            fptr_d   = '0;
            used_d   = '0;
            pend_d   = '0;
        end else begin
            if (push_i) begin
                pc_d[tail_q]     = push_pc_i;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + 1'b1;
            end
            if (fill_ok) begin
                instr_d[fptr_q]  = fill_data_i;
                filled_d[fptr_q] = 1'b1;
                fptr_d           = fptr_q + 1'b1;
            end
            if (pop_i) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            used_d = used_q + CW'(push_i) - CW'(pop_i);
            pend_d = pend_q + CW'(push_i) - CW'(fill_ok);
        end
    end

    // Slot storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            used_q   <= '0;
            pend_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fptr_q   <= fptr_d;
            used_q   <= used_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests,
// buffers up to DEPTH instructions and hands one per cycle to IF/ID.
// A redirect flushes the buffer; responses still owed for flushed requests
// are swallowed by an in-order drop counter.
module fetch_unit
    import core_pkg::NOP_INSTR;
    import core_pkg::PC_STEP;
#(
    parameter int unsigned     XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   used, pend;
    logic            head_filled;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            accept, pop, fill, rsp_taken;

    // Credits are shared by buffered slots and responses still to be dropped.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, used} + {1'b0, drop_q}) < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign out_valid = !rst && head_filled && !redirect_valid;
    assign out_instr = out_valid ? head_instr : XLEN'(NOP_INSTR);
    assign out_pc    = out_valid ? head_pc    : '0;
    assign pop       = out_valid && !stall;

    // Responses go to the drop counter first, then to the buffer.
    assign fill      = imem_rsp_valid && (drop_q == '0);
    assign rsp_taken = imem_rsp_valid && ((drop_q != '0) || (pend != '0));

    fetch_slot_fifo #(
        .XLEN (XLEN),
        .DEPTH(DEPTH)
    ) u_slots (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (accept),
        .push_pc_i    (pc_q),
        .fill_i       (fill),
        .fill_data_i  (imem_rsp_data),
        .pop_i        (pop),
        .head_filled_o(head_filled),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .used_o       (used),
        .pend_o       (pend)
    );

    // Next PC and drop count; redirect snapshots every still-owed response.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            drop_d = drop_q + pend - CW'(rsp_taken);
        end else begin
            if (accept) begin
                pc_d = pc_q + XLEN'(PC_STEP);
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    // PC and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // A response must always be owed to either the buffer or the drop counter.
    a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((drop_q != '0) || (pend != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        stall          = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_entry_t;

    // Memory model and fetch-stream reference state.
    mem_entry_t  memq[$];
    int          cyc, last_due, lat;
    int          held;      // current-epoch requests accepted and not yet delivered
    int          cur_ret;   // current-epoch responses returned and not yet delivered
    int          stale;     // pre-redirect responses still owed by memory
    logic [31:0] exp_req_pc, exp_out_pc;
    int          checks, failures;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit rsp_due_now();
        return (memq.size() > 0) && (memq[0].due <= cyc);
    endfunction

    task automatic model_reset();
        memq.delete();
        cyc = 0; last_due = -1;
        held = 0; cur_ret = 0; stale = 0;
        exp_req_pc = 32'h0; exp_out_pc = 32'h0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input bit rdy, input bit st, input bit rd, input logic [31:0] rpc);
        bit          rsp_now, exp_rv, exp_ov, acc, pp;
        mem_entry_t  e;
        int          due;
        @(negedge clk);
        imem_req_ready = rdy;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rsp_now        = rsp_due_now();
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(memq[0].addr) : $urandom;
        #1;
        exp_rv = ((held + stale) < DEPTH) && !rd;
        exp_ov = (cur_ret > 0) && !rd;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("out_pc", out_pc, exp_ov ? exp_out_pc : 32'h0);
        chk("out_instr", out_instr, exp_ov ? mem_word(exp_out_pc) : 32'h0000_0013);
        acc = exp_rv && rdy;
        pp  = exp_ov && !st;
        if (rsp_now) begin
            e = memq.pop_front();
            if (e.stale) stale--;
            else         cur_ret++;
        end
        if (rd) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            stale      = memq.size();
            held       = 0;
            cur_ret    = 0;
            exp_req_pc = rpc;
            exp_out_pc = rpc;
        end else begin
            if (acc) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: exp_req_pc, due: due, stale: 1'b0});
                held++;
                exp_req_pc += 32'd4;
            end
            if (pp) begin
                held--;
                cur_ret--;
                exp_out_pc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        bool_loop: begin end
        checks = 0; failures = 0; lat = 1;
        model_reset();

        // Reset state.
        #12;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'h0);
        release_reset();

        // 1: streaming with a 1-cycle memory.
        lat = 1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 2: memory not ready for 5 cycles, then first delivery two cycles later.
        rst = 1'b1; release_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        n = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        while (!out_valid && n < 10) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("t2_first_out_latency", n, 32'd2);

        // 3: stall 4 cycles in steady state.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 4: redirect with two requests in flight under 3-cycle latency.
        lat = 3;
        n = 0;
        while (!(held == 2 && cur_ret == 0 && stale == 0) && n < 20) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("t4_two_in_flight", held, 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 5: redirect coinciding with a response.
        lat = 1;
        n = 0;
        while (!rsp_due_now() && n < 20) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        chk("t5_rsp_pending", {31'b0, rsp_due_now()}, 32'h1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 6: reset pulse with both slots filled.
        n = 0;
        while (cur_ret < 2 && n < 20) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("t6_two_filled", cur_ret, 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_req_valid_in_rst", {31'b0, imem_req_valid}, 32'h0);
        chk("t6_out_valid_in_rst", {31'b0, out_valid}, 32'h0);
        chk("t6_out_pc_in_rst", out_pc, 32'h0);
        release_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Randomised traffic, including redirects near the top of the address space.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            bit          rd;
            if (i % 200 == 0) lat = $urandom_range(1, 3);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 25, rd, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
